mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one external single-port memory bus between the instruction-cache refill port and the data port (load refill plus stores) of the pipelined core.
- Stores are posted into a small write buffer so the MEM stage does not wait.
- Loads and instruction refills are blocking request/valid transactions.
- Fixed priority with a starvation limit guarantees forward progress for fetch.

Parameters:
STARVE_MAX, 4, max consecutive data-side grants while an instruction refill waits; the next grant after that goes to fetch (range 1..15)
WB_DEPTH, 2, write-buffer entries (power of 2, >=1)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
i_iread_en  input  1  instruction refill request (level, held until served)
i_iaddr  input  32  refill address, stable while i_iread_en high
o_iread_vd  output  1  one-cycle pulse: o_inst valid
o_inst  output  32  refilled instruction word
i_dread_en  input  1  data load refill request (level)
i_dwrite_en  input  1  store request (level)
i_daddr  input  32  data address
i_dwdata  input  32  store data
o_dread_vd  output  1  one-cycle pulse: o_drdata valid
o_drdata  output  32  load data
o_dstall  output  1  store cannot be accepted this cycle
o_mem_req  output  1  bus request
o_mem_we  output  1  1 = write, 0 = read
o_mem_addr  output  32  bus address
o_mem_wdata  output  32  bus write data
i_mem_ack  input  1  bus completion; i_mem_rdata valid on this cycle for reads
i_mem_rdata  input  32  bus read data
o_busy  output  1  FSM not IDLE or write buffer non-empty

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; write buffer emptied; starve counter=0.
  - All outputs 0.
  - Reset mid-transaction abandons the bus cycle: o_mem_req drops immediately and buffered stores are discarded.
- FSM states:
  - IDLE: arbitrate. On a grant, latch the request into bus registers and go to BUS.
  - BUS: o_mem_req=1 with addr/we/wdata held stable until i_mem_ack=1 is sampled.
    - Read: capture i_mem_rdata, go to RESP.
    - Write: pop the buffer head, go to IDLE.
  - RESP: exactly one cycle. Pulse o_iread_vd or o_dread_vd with registered data, then go to IDLE.
  - o_mem_req is low in IDLE and RESP, so there is at least 1 idle bus cycle between transactions.
  - The requester must drop its en in the cycle after RESP (cache fill lands at the RESP edge). The arbiter does not filter this.
- Read latency: i_*read_en high in IDLE with bus ack in 1 cycle -> vd pulse 3 cycles later (IDLE grant, BUS, RESP).
- Arbitration in IDLE (first match wins):
  1. Write buffer non-empty and not (i_iread_en and starve==STARVE_MAX) -> drain head write.
  2. i_dread_en and write buffer empty and not (i_iread_en and starve==STARVE_MAX) -> data read. Loads never bypass buffered stores (RAW safety).
  3. i_iread_en -> instruction read.
- Starve counter:
  - Increments on each data-side grant made while i_iread_en=1.
  - Clears on an instruction grant or whenever i_iread_en=0 in IDLE.
  - Saturates at STARVE_MAX.
- Write buffer:
  - FIFO of {addr, wdata}, count register 0..WB_DEPTH.
  - Push at the clock edge when i_dwrite_en=1 and count<WB_DEPTH. Each cycle with i_dwrite_en high pushes one entry.
  - o_dstall = i_dwrite_en & (count==WB_DEPTH), combinational. Full is judged on the registered count: a pop in the same cycle does not free space until the next cycle.
  - Push and pop in the same cycle (count not full) leave count unchanged.
  - Pointers wrap modulo WB_DEPTH.
  - Writes reach the bus in push order.
- Simultaneous i_dread_en and i_dwrite_en are legal. The store is buffered; the read waits until the buffer drains.
- o_inst and o_drdata hold their last value outside vd pulses.

Test Plan:
- Reset mid-BUS: assert rst while o_mem_req=1 with 2 buffered stores -> o_mem_req=0 the same cycle, o_busy=0, and no write is issued after rst releases.
- Single fetch: i_iread_en=1, i_iaddr=0x100, bus acks next cycle with 0x00500093 -> o_mem_we=0, o_mem_addr=0x100; o_iread_vd=1 with o_inst=0x00500093 exactly 3 cycles after request.
- Posted stores: stores (0x200, 0xAA), (0x204, 0xBB), (0x208, 0xCC) on consecutive cycles, bus acks after 3 cycles -> first two accepted, o_dstall=1 on the third until count<2; bus writes appear in order 0x200, 0x204, 0x208.
- RAW ordering: store (0x300, 0x55) followed by i_dread_en at 0x300 -> bus write to 0x300 completes before the bus read of 0x300 is issued; o_drdata=0x55 from the memory model.
- Starvation: STARVE_MAX=2, i_iread_en held while a store is pushed every cycle -> grant order write, write, ifetch; starve counter returns to 0 after the ifetch grant.
- Bus wait states: i_mem_ack held low for 5 cycles -> o_mem_addr, o_mem_we and o_mem_wdata unchanged across all 5 cycles; exactly one vd pulse results.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory bus between instruction refills and the data port.
// Stores are posted into a small FIFO; loads never overtake buffered stores.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned WB_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_iread_en,
  input  logic [31:0] i_iaddr,
  output logic        o_iread_vd,
  output logic [31:0] o_inst,
  input  logic        i_dread_en,
  input  logic        i_dwrite_en,
  input  logic [31:0] i_daddr,
  input  logic [31:0] i_dwdata,
  output logic        o_dread_vd,
  output logic [31:0] o_drdata,
  output logic        o_dstall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  localparam int unsigned PtrW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(WB_DEPTH + 1);
  localparam logic [3:0]      StarveMax = 4'(STARVE_MAX);
  localparam logic [CntW-1:0] WbFull    = CntW'(WB_DEPTH);
  localparam logic [PtrW-1:0] PtrLast   = PtrW'(WB_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e state_q, state_d;

  logic [31:0]     wb_addr_q [WB_DEPTH];
  logic [31:0]     wb_addr_d [WB_DEPTH];
  logic [31:0]     wb_data_q [WB_DEPTH];
  logic [31:0]     wb_data_d [WB_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      starve_q, starve_d;

  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        we_q, we_d, is_inst_q, is_inst_d;
  logic [31:0] inst_q, inst_d, drdata_q, drdata_d;

  logic wb_empty, wb_full, push, pop, starve_hit;
  logic gnt_wr, gnt_dr, gnt_if;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  assign wb_empty   = (cnt_q == '0);
  assign wb_full    = (cnt_q == WbFull);
  assign push       = i_dwrite_en && !wb_full;
  assign pop        = (state_q == StBus) && we_q && i_mem_ack;
  assign starve_hit = i_iread_en && (starve_q == StarveMax);

  // A store arriving this cycle also blocks the load so it cannot slip past it.
  assign gnt_wr = (state_q == StIdle) && !wb_empty && !starve_hit;
  assign gnt_dr = (state_q == StIdle) && !gnt_wr && i_dread_en && wb_empty && !i_dwrite_en &&
                  !starve_hit;
  assign gnt_if = (state_q == StIdle) && !gnt_wr && !gnt_dr && i_iread_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_wr || gnt_dr || gnt_if) state_d = StBus;
      StBus:   if (i_mem_ack) state_d = we_q ? StIdle : StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_mem_req   = (state_q == StBus);
    o_mem_we    = we_q;
    o_mem_addr  = addr_q;
    o_mem_wdata = wdata_q;
    o_iread_vd  = (state_q == StResp) && is_inst_q;
    o_dread_vd  = (state_q == StResp) && !is_inst_q;
    o_inst      = inst_q;
    o_drdata    = drdata_q;
    o_dstall    = i_dwrite_en && wb_full;
    o_busy      = (state_q != StIdle) || !wb_empty;
  end

  always_comb begin
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    is_inst_d = is_inst_q;
    inst_d    = inst_q;
    drdata_d  = drdata_q;
    if (gnt_wr) begin
      addr_d    = wb_addr_q[rd_ptr_q];
      wdata_d   = wb_data_q[rd_ptr_q];
      we_d      = 1'b1;
      is_inst_d = 1'b0;
    end else if (gnt_dr) begin
      addr_d    = i_daddr;
      wdata_d   = '0;
      we_d      = 1'b0;
      is_inst_d = 1'b0;
    end else if (gnt_if) begin
      addr_d    = i_iaddr;
      wdata_d   = '0;
      we_d      = 1'b0;
      is_inst_d = 1'b1;
    end
    if ((state_q == StBus) && i_mem_ack && !we_q) begin
      if (is_inst_q) begin
        inst_d = i_mem_rdata;
      end else begin
        drdata_d = i_mem_rdata;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (state_q == StIdle) begin
      if (!i_iread_en || gnt_if) begin
        starve_d = '0;
      end else if ((gnt_wr || gnt_dr) && (starve_q != StarveMax)) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_comb begin
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (push) begin
      wb_addr_d[wr_ptr_q] = i_daddr;
      wb_data_d[wr_ptr_q] = i_dwdata;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      is_inst_q <= 1'b0;
      inst_q    <= '0;
      drdata_q  <= '0;
      starve_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      for (int unsigned i = 0; i < WB_DEPTH; i++) begin
        wb_addr_q[i] <= '0;
        wb_data_q[i] <= '0;
      end
    end else begin
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      is_inst_q <= is_inst_d;
      inst_q    <= inst_d;
      drdata_q  <= drdata_d;
      starve_q  <= starve_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

endmodule
